// File: rtl/of_pkg.sv
// Shared types and sizes for the operand fetch stage.
package of_pkg;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      rd_we;
  } of_issue_t;
endpackage

// File: rtl/of_scoreboard.sv
// Per-register busy tracking for outstanding writebacks; reports RAW/WAW hazards
// for the instruction currently presented by decode.
module of_scoreboard
  import of_pkg::*;
#(
  parameter int NREG = NUM_REGS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  reg_addr_t       set_addr,
  input  logic [NREG-1:0] clr,
  input  of_issue_t       iss,
  output logic [NREG-1:0] busy,
  output logic            hazard
);
  logic [NREG-1:0] busy_q, busy_d;

  // A writeback landing this cycle already satisfies the dependency.
  function automatic logic pending(input reg_addr_t a);
    return (a != '0) && busy_q[a] && !clr[a];
  endfunction

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (clr[r]) busy_d[r] = 1'b0;
      if (set_en && set_addr == reg_addr_t'(r)) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy   = busy_q;
  assign hazard = pending(iss.rs1) || pending(iss.rs2) || (iss.rd_we && pending(iss.rd));
endmodule

// File: rtl/operand_fetch_stage.sv
// Decode->execute operand fetch: register file read/write, writeback bypass,
// busy scoreboard and output pipeline register. Optional counters under OPERAND_FETCH_STATS_EN.
module operand_fetch_stage
  import of_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int NREG = NUM_REGS,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_rd_we,
  output logic [AW-1:0]   rf_rd_addr0,
  output logic [AW-1:0]   rf_rd_addr1,
  input  logic [N-1:0]    rf_rd_data0,
  input  logic [N-1:0]    rf_rd_data1,
  output logic            rf_wr_ena,
  output logic [AW-1:0]   rf_wr_addr,
  output logic [N-1:0]    rf_wr_data,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [N-1:0]    wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [N-1:0]    ex_op0,
  output logic [N-1:0]    ex_op1,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_rd_we,
  output logic [NREG-1:0] busy
`ifdef OPERAND_FETCH_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_stalls
`endif
);
  logic [NREG-1:0] clr;
  logic            hazard, fire;
  logic [N-1:0]    op0_sel, op1_sel;
  of_issue_t       iss;

  logic            ex_valid_q;
  logic [N-1:0]    ex_op0_q, ex_op1_q;
  logic [AW-1:0]   ex_rd_q;
  logic            ex_rd_we_q;

  assign rf_rd_addr0 = id_rs1;
  assign rf_rd_addr1 = id_rs2;
  assign rf_wr_addr  = wb_addr;
  assign rf_wr_data  = wb_data;
  assign rf_wr_ena   = wb_valid && (wb_addr != '0);

  for (genvar r = 0; r < NREG; r++) begin : g_clr
    if (r == 0) begin : g_zero
      assign clr[r] = 1'b0;
    end else begin : g_reg
      assign clr[r] = wb_valid && (wb_addr == AW'(r));
    end
  end

  // The register file only updates at the edge, so a same-cycle writeback is bypassed.
  assign op0_sel = (id_rs1 == '0) ? '0 : clr[id_rs1] ? wb_data : rf_rd_data0;
  assign op1_sel = (id_rs2 == '0) ? '0 : clr[id_rs2] ? wb_data : rf_rd_data1;

  assign iss      = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd, rd_we: id_rd_we};
  assign id_ready = (!ex_valid_q || ex_ready) && !hazard;
  assign fire     = id_valid && id_ready;

  of_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (fire && id_rd_we),
    .set_addr (id_rd),
    .clr      (clr),
    .iss      (iss),
    .busy     (busy),
    .hazard   (hazard)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_op0_q   <= '0;
      ex_op1_q   <= '0;
      ex_rd_q    <= '0;
      ex_rd_we_q <= 1'b0;
    end else if (fire) begin
      ex_valid_q <= 1'b1;
      ex_op0_q   <= op0_sel;
      ex_op1_q   <= op1_sel;
      ex_rd_q    <= id_rd;
      ex_rd_we_q <= id_rd_we;
    end else if (ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op0   = ex_op0_q;
  assign ex_op1   = ex_op1_q;
  assign ex_rd    = ex_rd_q;
  assign ex_rd_we = ex_rd_we_q;

`ifdef OPERAND_FETCH_STATS_EN
  logic [31:0] stat_issued_q, stat_stalls_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issued_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (fire)                  stat_issued_q <= stat_issued_q + 32'd1;
      if (id_valid && !id_ready) stat_stalls_q <= stat_stalls_q + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stalls = stat_stalls_q;
`endif
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench: stimulus pushes expected execute payloads, a monitor pops and compares them.
module tb_operand_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready, id_rd_we;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [4:0]  rf_rd_addr0, rf_rd_addr1, rf_wr_addr;
  logic [31:0] rf_rd_data0, rf_rd_data1, rf_wr_data;
  logic        rf_wr_ena;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready, ex_rd_we;
  logic [31:0] ex_op0, ex_op1;
  logic [4:0]  ex_rd;
  logic [31:0] busy;

  typedef struct packed {
    logic [31:0] op0;
    logic [31:0] op1;
    logic [4:0]  rd;
    logic        rd_we;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
    .rf_wr_ena(rf_wr_ena), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op0(ex_op0), .ex_op1(ex_op1), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .busy(busy)
  );

  // Simple register file driven by the DUT's write port.
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(posedge clk) if (rf_wr_ena) rf[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data0 = rf[rf_rd_addr0];
  assign rf_rd_data1 = rf[rf_rd_addr1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted execute transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      if (expq.size() == 0) begin
        chk("ex_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = expq.pop_front();
        chk("ex_op0", 64'(ex_op0), 64'(mon_e.op0));
        chk("ex_op1", 64'(ex_op1), 64'(mon_e.op1));
        chk("ex_rd", 64'(ex_rd), 64'(mon_e.rd));
        chk("ex_rd_we", 64'(ex_rd_we), 64'(mon_e.rd_we));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic we);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_rd_we = we;
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; ex_ready = 1'b1;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ex_op0", 64'(ex_op0), 64'd0);
    chk("rst_ex_rd", 64'(ex_rd), 64'd0);
    nxt(); rst = 1'b1;

    // T1: write x5
    nxt(); wb(1, 5, 32'hDEADBEEF);
    @(negedge clk); chk("wb5_ena", 64'(rf_wr_ena), 64'd1);
    // T2: read x5 and x0
    nxt(); wb(0, 0, 0); issue(1, 5, 0, 0, 0);
    @(negedge clk); chk("t2_ready", 64'(id_ready), 64'd1);
    expq.push_back('{op0: 32'hDEADBEEF, op1: 32'h0, rd: 5'd0, rd_we: 1'b0});
    // T3: write-pending rd=7
    nxt(); issue(1, 0, 0, 7, 1);
    @(negedge clk);
    chk("latency_ex_valid", 64'(ex_valid), 64'd1);
    chk("t3_ready", 64'(id_ready), 64'd1);
    expq.push_back('{op0: 32'h0, op1: 32'h0, rd: 5'd7, rd_we: 1'b1});
    // T4,T5: RAW on x7 stalls
    for (int i = 0; i < 2; i++) begin
      nxt(); issue(1, 7, 0, 0, 0);
      @(negedge clk);
      chk("raw_stall_ready", 64'(id_ready), 64'd0);
      chk("busy7_set", 64'(busy[7]), 64'd1);
    end
    // T6: writeback x7 releases the stall with bypass
    nxt(); wb(1, 7, 32'h1234);
    @(negedge clk);
    chk("bypass_ready", 64'(id_ready), 64'd1);
    expq.push_back('{op0: 32'h1234, op1: 32'h0, rd: 5'd0, rd_we: 1'b0});
    // T7: set and clear x3 in the same cycle
    nxt(); wb(1, 3, 32'h33); issue(1, 0, 0, 3, 1);
    @(negedge clk);
    chk("busy7_clr", 64'(busy[7]), 64'd0);
    chk("t7_ready", 64'(id_ready), 64'd1);
    expq.push_back('{op0: 32'h0, op1: 32'h0, rd: 5'd3, rd_we: 1'b1});
    // T8: idle
    nxt(); wb(0, 0, 0); issue(0, 0, 0, 0, 0);
    @(negedge clk); chk("set_wins_busy3", 64'(busy[3]), 64'd1);
    // T9: read x5,x7 from the register file
    nxt(); issue(1, 5, 7, 0, 0);
    @(negedge clk); chk("t9_ready", 64'(id_ready), 64'd1);
    expq.push_back('{op0: 32'hDEADBEEF, op1: 32'h1234, rd: 5'd0, rd_we: 1'b0});
    // T10-T13: backpressure holds execute payload
    for (int i = 0; i < 4; i++) begin
      nxt(); ex_ready = 1'b0; issue(1, 0, 5, 2, 0);
      @(negedge clk);
      chk("hold_ready", 64'(id_ready), 64'd0);
      chk("hold_valid", 64'(ex_valid), 64'd1);
      chk("hold_op0", 64'(ex_op0), 64'hDEADBEEF);
      chk("hold_op1", 64'(ex_op1), 64'h1234);
    end
    // T14: release accepts in the same cycle
    nxt(); ex_ready = 1'b1;
    @(negedge clk); chk("release_ready", 64'(id_ready), 64'd1);
    expq.push_back('{op0: 32'h0, op1: 32'hDEADBEEF, rd: 5'd2, rd_we: 1'b0});
    // T15: writeback to x0 is dropped
    nxt(); issue(0, 0, 0, 0, 0); wb(1, 0, 32'hFFFFFFFF);
    @(negedge clk); chk("wb0_ena", 64'(rf_wr_ena), 64'd0);
    // T16: x0 reads as zero, mark x9 busy
    nxt(); wb(0, 0, 0); issue(1, 0, 0, 9, 1);
    @(negedge clk); chk("t16_ready", 64'(id_ready), 64'd1);
    expq.push_back('{op0: 32'h0, op1: 32'h0, rd: 5'd9, rd_we: 1'b1});
    // T17: hold, then async reset mid-cycle
    nxt(); issue(0, 0, 0, 0, 0); ex_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy9", 64'(busy[9]), 64'd1);
    chk("pre_rst_valid", 64'(ex_valid), 64'd1);
    #2; rst = 1'b0; wb(1, 4, 32'h44);
    #1;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_valid", 64'(ex_valid), 64'd0);
    chk("async_op0", 64'(ex_op0), 64'd0);
    chk("rst_wb_ena", 64'(rf_wr_ena), 64'd1);
    expq.pop_back();
    chk("queue_drained", 64'(expq.size()), 64'd0);
    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
